// File: rtl/aap_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : aap_fetch_unit
//  Brief    : Single-outstanding instruction fetch for 16/32-bit AAP encodings.
//  Revision : 1.0
// ============================================================================
module aap_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic        instr_long,
    output logic [15:0] instr_pc
);

    localparam logic [2:0] c_REQ_LO  = 3'd0;
    localparam logic [2:0] c_WAIT_LO = 3'd1;
    localparam logic [2:0] c_REQ_HI  = 3'd2;
    localparam logic [2:0] c_WAIT_HI = 3'd3;
    localparam logic [2:0] c_PRESENT = 3'd4;
    localparam logic [2:0] c_DRAIN   = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_pc_step;
    logic        w_cap_lo;
    logic        w_cap_hi;
    logic [31:0] r_instr_data;
    logic        r_instr_long;
    logic [15:0] r_instr_pc;

    assign w_pc_step = r_instr_long ? 16'd2 : 16'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_REQ_LO;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cap_lo    = 1'b0;
        w_cap_hi    = 1'b0;
        if (branch_valid) begin
            // A request still in flight must be drained before refetching
            w_pc_nxt = branch_target;
            case (r_state)
                c_WAIT_LO, c_WAIT_HI, c_DRAIN:
                    w_state_nxt = imem_rvalid ? c_REQ_LO : c_DRAIN;
                default:
                    w_state_nxt = c_REQ_LO;
            endcase
        end else begin
            case (r_state)
                c_REQ_LO: w_state_nxt = c_WAIT_LO;
                c_WAIT_LO: begin
                    if (imem_rvalid) begin
                        w_cap_lo    = 1'b1;
                        w_state_nxt = imem_rdata[15] ? c_REQ_HI : c_PRESENT;
                    end
                end
                c_REQ_HI: w_state_nxt = c_WAIT_HI;
                c_WAIT_HI: begin
                    if (imem_rvalid) begin
                        w_cap_hi    = 1'b1;
                        w_state_nxt = c_PRESENT;
                    end
                end
                c_PRESENT: begin
                    if (instr_ready) begin
                        w_pc_nxt    = r_pc + w_pc_step;
                        w_state_nxt = c_REQ_LO;
                    end
                end
                c_DRAIN: begin
                    if (imem_rvalid) begin
                        w_state_nxt = c_REQ_LO;
                    end
                end
                default: w_state_nxt = c_REQ_LO;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr_data <= 32'h0000_0000;
            r_instr_long <= 1'b0;
            r_instr_pc   <= 16'h0000;
        end else if (w_cap_lo) begin
            r_instr_data <= {16'h0000, imem_rdata};
            r_instr_long <= 1'b0;
            r_instr_pc   <= r_pc;
        end else if (w_cap_hi) begin
            r_instr_data[31:16] <= imem_rdata;
            r_instr_long        <= 1'b1;
        end
    end

    // A redirect in a request cycle cancels the request so only one is ever outstanding
    assign imem_req    = ((r_state == c_REQ_LO) || (r_state == c_REQ_HI)) && !branch_valid && !reset;
    assign imem_addr   = (r_state == c_REQ_HI) ? (r_pc + 16'd1) : r_pc;
    assign instr_valid = (r_state == c_PRESENT);
    assign instr_data  = r_instr_data;
    assign instr_long  = r_instr_long;
    assign instr_pc    = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_aap_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aap_fetch_unit
//  Brief    : Scoreboard bench for aap_fetch_unit (main instance + wrap instance).
//  Revision : 1.0
// ============================================================================
module tb_aap_fetch_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        req0, rvalid0, bv, iv0, ir0, il0;
    logic [15:0] addr0, rdata0, bt, ipc0;
    logic [31:0] id0;
    logic        req1, rvalid1, iv1, il1;
    logic [15:0] addr1, rdata1, ipc1;
    logic [31:0] id1;

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 1;
    logic [48:0] exp_q [$];
    logic [15:0] addr_q [$];
    int d1_addr_n = 0;
    bit d1_done   = 1'b0;

    aap_fetch_unit #(.RESET_PC(16'h0000)) u_dut0 (
        .clock(clock), .reset(reset),
        .imem_req(req0), .imem_addr(addr0), .imem_rvalid(rvalid0), .imem_rdata(rdata0),
        .branch_valid(bv), .branch_target(bt),
        .instr_valid(iv0), .instr_ready(ir0), .instr_data(id0), .instr_long(il0), .instr_pc(ipc0)
    );

    aap_fetch_unit #(.RESET_PC(16'hFFFF)) u_dut1 (
        .clock(clock), .reset(reset),
        .imem_req(req1), .imem_addr(addr1), .imem_rvalid(rvalid1), .imem_rdata(rdata1),
        .branch_valid(1'b0), .branch_target(16'h0000),
        .instr_valid(iv1), .instr_ready(1'b1), .instr_data(id1), .instr_long(il1), .instr_pc(ipc1)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 16'h5555;
            16'h0001: mem_word = 16'h1234;
            16'h0002: mem_word = 16'h2345;
            16'h0003: mem_word = 16'h3456;
            16'h0004: mem_word = 16'h8A01;
            16'h0005: mem_word = 16'h8123;
            16'h0006: mem_word = 16'h0666;
            16'hFFFF: mem_word = 16'h8000;
            default:  mem_word = {4'h0, a[11:0]};
        endcase
    endfunction

    function automatic logic [15:0] d1_exp_addr(input int n);
        case (n)
            0:       d1_exp_addr = 16'hFFFF;
            1:       d1_exp_addr = 16'h0000;
            default: d1_exp_addr = 16'h0001;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int limit);
        n_checks++;
        n_errors++;
        $display("FAIL timeout_%s: event not seen within %0d cycles", name, limit);
    endtask

    task automatic wait_exp_empty(input int limit);
        int n = 0;
        @(negedge clock);
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (n >= limit) timeout("exp_empty", limit);
    endtask

    task automatic wait_iv(input int limit);
        int n = 0;
        @(negedge clock);
        while (!iv0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (n >= limit) timeout("instr_valid", limit);
    endtask

    task automatic wait_req_addr(input logic [15:0] a, input int limit);
        int n = 0;
        @(negedge clock);
        while (!(req0 && addr0 == a) && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (n >= limit) timeout("imem_req_addr", limit);
    endtask

    // Memory for the main instance: one outstanding request, latency mem_lat
    logic        pend0;
    logic [15:0] paddr0;
    int          cnt0;
    always @(posedge clock) begin
        if (reset) begin
            pend0   <= 1'b0;
            rvalid0 <= 1'b0;
            rdata0  <= 16'h0000;
        end else begin
            rvalid0 <= 1'b0;
            rdata0  <= 16'hDEAD;
            if (req0) begin
                if (mem_lat <= 1) begin
                    rvalid0 <= 1'b1;
                    rdata0  <= mem_word(addr0);
                end else begin
                    pend0  <= 1'b1;
                    paddr0 <= addr0;
                    cnt0   <= mem_lat - 2;
                end
            end else if (pend0) begin
                if (cnt0 == 0) begin
                    rvalid0 <= 1'b1;
                    rdata0  <= mem_word(paddr0);
                    pend0   <= 1'b0;
                end else begin
                    cnt0 <= cnt0 - 1;
                end
            end
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            rvalid1 <= 1'b0;
            rdata1  <= 16'h0000;
        end else begin
            rvalid1 <= req1;
            rdata1  <= req1 ? mem_word(addr1) : 16'hBEEF;
        end
    end

    // Instruction scoreboard monitor
    initial begin
        logic [48:0] e;
        forever begin
            @(negedge clock);
            if (!reset && iv0 && ir0 && !bv) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL instr_unexpected: got data=%h pc=%h required none", id0, ipc0);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_data", 64'(id0), 64'(e[48:17]));
                    chk("instr_long", 64'(il0), 64'(e[16]));
                    chk("instr_pc", 64'(ipc0), 64'(e[15:0]));
                end
            end
        end
    end

    // Request address monitor
    initial begin
        logic [15:0] a;
        forever begin
            @(negedge clock);
            if (!reset && req0) begin
                if (addr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL imem_req_unexpected: got addr=%h required none", addr0);
                end else begin
                    a = addr_q.pop_front();
                    chk("imem_addr", 64'(addr0), 64'(a));
                end
            end
        end
    end

    // Wrap instance monitor
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (req1 && d1_addr_n < 3) begin
                    chk("wrap_addr", 64'(addr1), 64'(d1_exp_addr(d1_addr_n)));
                    d1_addr_n++;
                end
                if (iv1 && !d1_done) begin
                    chk("wrap_data", 64'(id1), 64'h5555_8000);
                    chk("wrap_long", 64'(il1), 64'd1);
                    chk("wrap_pc", 64'(ipc1), 64'hFFFF);
                    d1_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bv    = 1'b0;
        bt    = 16'h0000;
        ir0   = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_instr_valid", 64'(iv0), 64'd0);
        chk("rst_imem_req", 64'(req0), 64'd0);
        chk("rst_instr_data", 64'(id0), 64'd0);
        chk("rst_instr_long", 64'(il0), 64'd0);
        chk("rst_instr_pc", 64'(ipc0), 64'd0);
        chk("rst_wrap_valid", 64'(iv1), 64'd0);

        exp_q.push_back({32'h0000_5555, 1'b0, 16'h0000});
        exp_q.push_back({32'h0000_1234, 1'b0, 16'h0001});
        exp_q.push_back({32'h0000_2345, 1'b0, 16'h0002});
        exp_q.push_back({32'h0000_3456, 1'b0, 16'h0003});
        exp_q.push_back({32'h8123_8A01, 1'b1, 16'h0004});
        for (int i = 0; i <= 6; i++) addr_q.push_back(16'(i));
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("first_req", {47'd0, req0, addr0}, 64'h1_0000);
        @(negedge clock);
        chk("lat16_not_yet", 64'(iv0), 64'd0);
        @(negedge clock);
        chk("lat16_valid", 64'(iv0), 64'd1);

        wait_exp_empty(200);
        @(posedge clock);
        #1 ir0 = 1'b0;

        exp_q.push_back({32'h0000_0666, 1'b0, 16'h0006});
        wait_iv(50);
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold", {13'd0, iv0, req0, il0, ipc0, id0},
                {13'd0, 1'b1, 1'b0, 1'b0, 16'h0006, 32'h0000_0666});
            @(negedge clock);
        end

        mem_lat = 3;
        addr_q.push_back(16'h0007);
        addr_q.push_back(16'h0100);
        addr_q.push_back(16'h0101);
        exp_q.push_back({32'h0000_0100, 1'b0, 16'h0100});
        @(posedge clock);
        #1 ir0 = 1'b1;
        wait_req_addr(16'h0007, 20);
        @(posedge clock);
        #1 begin bv = 1'b1; bt = 16'h0100; end
        @(posedge clock);
        #1 bv = 1'b0;
        wait_exp_empty(100);
        @(posedge clock);
        #1 ir0 = 1'b0;

        wait_iv(50);
        mem_lat = 1;
        addr_q.push_back(16'hFFFF);
        addr_q.push_back(16'h0000);
        addr_q.push_back(16'h0001);
        addr_q.push_back(16'h0002);
        exp_q.push_back({32'h5555_8000, 1'b1, 16'hFFFF});
        exp_q.push_back({32'h0000_1234, 1'b0, 16'h0001});
        @(posedge clock);
        #1 begin ir0 = 1'b1; bv = 1'b1; bt = 16'hFFFF; end
        @(posedge clock);
        #1 bv = 1'b0;
        @(negedge clock);
        chk("drop_ready_valid", 64'(iv0), 64'd0);
        chk("branch_req", {47'd0, req0, addr0}, 64'h1_FFFF);
        wait_exp_empty(100);
        @(posedge clock);
        #1 ir0 = 1'b0;

        wait_iv(50);
        mem_lat = 3;
        addr_q.push_back(16'h0004);
        addr_q.push_back(16'h0005);
        @(posedge clock);
        #1 begin bv = 1'b1; bt = 16'h0004; end
        @(posedge clock);
        #1 bv = 1'b0;
        @(negedge clock);
        chk("drop_stall_valid", 64'(iv0), 64'd0);
        wait_req_addr(16'h0005, 30);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rst2_instr_valid", 64'(iv0), 64'd0);
        chk("rst2_imem_req", 64'(req0), 64'd0);
        chk("rst2_instr_data", 64'(id0), 64'd0);
        chk("rst2_instr_long", 64'(il0), 64'd0);
        chk("rst2_instr_pc", 64'(ipc0), 64'd0);

        mem_lat = 1;
        ir0     = 1'b1;
        exp_q.push_back({32'h0000_5555, 1'b0, 16'h0000});
        addr_q.push_back(16'h0000);
        addr_q.push_back(16'h0001);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("first_req_after_rst2", {47'd0, req0, addr0}, 64'h1_0000);
        wait_exp_empty(50);
        @(posedge clock);
        #1 ir0 = 1'b0;
        wait_iv(20);

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("addr_q_drained", 64'(addr_q.size()), 64'd0);
        chk("wrap_seen", 64'((d1_addr_n == 3) && d1_done), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
